// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, NOP encoding and fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          NB_PC     = 32;
    localparam int          NB_INSTR  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALTED    = 2'd1,
        STEP_WAIT = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_dec_register.sv
`default_nettype none
// ============================================================================
// Module      : if_dec_register
// Description : IF/ID pipeline register with flush (bubble), load and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module if_dec_register #(
    parameter int NB_PC    = cpu_pkg::NB_PC,
    parameter int NB_INSTR = cpu_pkg::NB_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                i_load,
    input  logic [NB_INSTR-1:0] i_instr,
    input  logic [NB_PC-1:0]    i_pc_plus4,
    output logic [NB_INSTR-1:0] o_instr,
    output logic [NB_PC-1:0]    o_pc_plus4,
    output logic                o_valid
);
    import cpu_pkg::*;

    logic [NB_INSTR-1:0] r_instr;
    logic [NB_PC-1:0]    r_pc_plus4;
    logic                r_valid;

    // Flush wins over load so a wrong-path fetch never enters decode.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr    <= NB_INSTR'(NOP_INSTR);
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction fetch: PC, sync imem address, IF/ID register,
//               stall/redirect/halt handling. Optional single-step support
//               when FETCH_STEP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int               NB_PC        = cpu_pkg::NB_PC,
    parameter int               NB_INSTR     = cpu_pkg::NB_INSTR,
    parameter int               NB_IMEM_ADDR = 10,
    parameter logic [NB_PC-1:0] RESET_PC     = '0
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    pc_write_i,
    input  logic                    if_dec_write_i,
    input  logic                    redirect_i,
    input  logic [NB_PC-1:0]        redirect_pc_i,
    input  logic                    halt_i,
`ifdef FETCH_STEP_EN
    input  logic                    step_mode_i,
    input  logic                    step_i,
`endif
    output logic [NB_IMEM_ADDR-1:0] imem_addr_o,
    input  logic [NB_INSTR-1:0]     imem_data_i,
    output logic [NB_INSTR-1:0]     if_dec_instr_o,
    output logic [NB_PC-1:0]        if_dec_pc_plus4_o,
    output logic                    if_dec_valid_o,
    output logic [NB_PC-1:0]        pc_o,
    output logic                    halted_o
);
    import cpu_pkg::*;

    fetch_state_e     r_state;
    logic             r_halted;
    logic [NB_PC-1:0] r_pc;
    logic [NB_PC-1:0] w_pc_plus4;
    logic [NB_PC-1:0] w_next_pc;
    logic             w_stop;
    logic             w_advance;
    logic             w_flush;
    logic             w_load;

    assign w_pc_plus4 = r_pc + NB_PC'(4);
    assign w_stop     = r_halted || halt_i;

`ifdef FETCH_STEP_EN
    assign w_advance = ((r_state == RUN) && !step_mode_i) || step_i;
`else
    assign w_advance = 1'b1;
`endif

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (reset_i) begin
            w_next_pc = RESET_PC;
        end else if (redirect_i) begin
            w_next_pc = redirect_pc_i;
        end else if (w_stop || !pc_write_i || !w_advance) begin
            w_next_pc = r_pc;
        end
    end

    // A hazard hold of IF/ID outranks a step-wait bubble so a stalled ID
    // instruction is never dropped.
    assign w_flush = redirect_i || w_stop || (if_dec_write_i && !w_advance);
    assign w_load  = if_dec_write_i && w_advance;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN, STEP_WAIT: begin
                    if (halt_i && !redirect_i) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end
`ifdef FETCH_STEP_EN
                    else if (step_mode_i) begin
                        r_state <= STEP_WAIT;
                    end else begin
                        r_state <= RUN;
                    end
`endif
                end
                HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    if_dec_register #(
        .NB_PC    (NB_PC),
        .NB_INSTR (NB_INSTR)
    ) u_if_dec_register (
        .clk        (clock_i),
        .rst        (reset_i),
        .i_flush    (w_flush),
        .i_load     (w_load),
        .i_instr    (imem_data_i),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (if_dec_instr_o),
        .o_pc_plus4 (if_dec_pc_plus4_o),
        .o_valid    (if_dec_valid_o)
    );

    assign imem_addr_o = w_next_pc[NB_IMEM_ADDR+1:2];
    assign pc_o        = r_pc;
    assign halted_o    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage (mem[i]=0x1000_0000+i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk            = 1'b0;
    logic        reset_i        = 1'b1;
    logic        pc_write_i     = 1'b1;
    logic        if_dec_write_i = 1'b1;
    logic        redirect_i     = 1'b0;
    logic [31:0] redirect_pc_i  = 32'h0;
    logic        halt_i         = 1'b0;
`ifdef FETCH_STEP_EN
    logic        step_mode_i    = 1'b0;
    logic        step_i         = 1'b0;
`endif
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= 32'h1000_0000 + {22'd0, imem_addr};

    fetch_stage #(
        .NB_PC        (32),
        .NB_INSTR     (32),
        .NB_IMEM_ADDR (10),
        .RESET_PC     (32'h0)
    ) dut (
        .clock_i           (clk),
        .reset_i           (reset_i),
        .pc_write_i        (pc_write_i),
        .if_dec_write_i    (if_dec_write_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .halt_i            (halt_i),
`ifdef FETCH_STEP_EN
        .step_mode_i       (step_mode_i),
        .step_i            (step_i),
`endif
        .imem_addr_o       (imem_addr),
        .imem_data_i       (imem_data),
        .if_dec_instr_o    (instr),
        .if_dec_pc_plus4_o (pc_plus4),
        .if_dec_valid_o    (valid),
        .pc_o              (pc),
        .halted_o          (halted)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset_i = 1'b1; pc_write_i = 1'b1; if_dec_write_i = 1'b1;
        redirect_i = 1'b0; halt_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%h required=%h", instr, 32'h0); end
        checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc_plus4 actual=%h required=%h", pc_plus4, 32'h0); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted actual=%b required=0", halted); end
        checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL reset_addr actual=%0d required=0", imem_addr); end
        reset_i = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++; if (instr !== 32'h1000_0000 + k - 1) begin failures++; $display("FAIL seq_instr[%0d] actual=%h required=%h", k, instr, 32'h1000_0000 + k - 1); end
            checks++; if (pc_plus4 !== 32'(4 * k)) begin failures++; $display("FAIL seq_pc_plus4[%0d] actual=%h required=%h", k, pc_plus4, 4 * k); end
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] actual=%b required=1", k, valid); end
            checks++; if (pc !== 32'(4 * k)) begin failures++; $display("FAIL seq_pc[%0d] actual=%h required=%h", k, pc, 4 * k); end
        end
    endtask

    task automatic test_stall();
        pc_write_i = 1'b0; if_dec_write_i = 1'b0;
        #1;
        checks++; if (imem_addr !== 10'd2) begin failures++; $display("FAIL stall_addr0 actual=%0d required=2", imem_addr); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d] actual=%h required=%h", c, pc, 32'h8); end
            checks++; if (instr !== 32'h1000_0001) begin failures++; $display("FAIL stall_instr[%0d] actual=%h required=%h", c, instr, 32'h1000_0001); end
            checks++; if (pc_plus4 !== 32'h8) begin failures++; $display("FAIL stall_pc_plus4[%0d] actual=%h required=%h", c, pc_plus4, 32'h8); end
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] actual=%b required=1", c, valid); end
            checks++; if (imem_addr !== 10'd2) begin failures++; $display("FAIL stall_addr[%0d] actual=%0d required=2", c, imem_addr); end
        end
        pc_write_i = 1'b1; if_dec_write_i = 1'b1;
        @(negedge clk);
        checks++; if (instr !== 32'h1000_0002) begin failures++; $display("FAIL resume_instr actual=%h required=%h", instr, 32'h1000_0002); end
        checks++; if (pc_plus4 !== 32'hC) begin failures++; $display("FAIL resume_pc_plus4 actual=%h required=%h", pc_plus4, 32'hC); end
        checks++; if (pc !== 32'hC) begin failures++; $display("FAIL resume_pc actual=%h required=%h", pc, 32'hC); end
    endtask

    task automatic test_redirect();
        pc_write_i = 1'b0; if_dec_write_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        #1;
        checks++; if (imem_addr !== 10'd16) begin failures++; $display("FAIL redir_addr actual=%0d required=16", imem_addr); end
        @(negedge clk);
        checks++; if (pc !== 32'h40) begin failures++; $display("FAIL redir_pc actual=%h required=%h", pc, 32'h40); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL redir_valid actual=%b required=0", valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL redir_instr_nop actual=%h required=%h", instr, 32'h0); end
        redirect_i = 1'b0; pc_write_i = 1'b1; if_dec_write_i = 1'b1;
        @(negedge clk);
        checks++; if (instr !== 32'h1000_0010) begin failures++; $display("FAIL redir_target_instr actual=%h required=%h", instr, 32'h1000_0010); end
        checks++; if (pc_plus4 !== 32'h44) begin failures++; $display("FAIL redir_pc_plus4 actual=%h required=%h", pc_plus4, 32'h44); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL redir_target_valid actual=%b required=1", valid); end
    endtask

    task automatic test_halt();
        apply_reset();
        repeat (8) @(negedge clk);
        checks++; if (pc !== 32'h20) begin failures++; $display("FAIL halt_pre_pc actual=%h required=%h", pc, 32'h20); end
        halt_i = 1'b1;
        @(negedge clk);
        halt_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag[%0d] actual=%b required=1", c, halted); end
            checks++; if (pc !== 32'h20) begin failures++; $display("FAIL halt_pc[%0d] actual=%h required=%h", c, pc, 32'h20); end
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL halt_valid[%0d] actual=%b required=0", c, valid); end
            checks++; if (imem_addr !== 10'd8) begin failures++; $display("FAIL halt_addr[%0d] actual=%0d required=8", c, imem_addr); end
            @(negedge clk);
        end
        reset_i = 1'b1;
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL halt_reset_pc actual=%h required=%h", pc, 32'h0); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset_flag actual=%b required=0", halted); end
        reset_i = 1'b0;
    endtask

    task automatic test_halt_redirect();
        repeat (2) @(negedge clk);
        halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80;
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hr_halted actual=%b required=0", halted); end
        checks++; if (pc !== 32'h80) begin failures++; $display("FAIL hr_pc actual=%h required=%h", pc, 32'h80); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL hr_valid actual=%b required=0", valid); end
        halt_i = 1'b0; redirect_i = 1'b0;
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hr_halted_after actual=%b required=0", halted); end
        checks++; if (instr !== 32'h1000_0020) begin failures++; $display("FAIL hr_instr actual=%h required=%h", instr, 32'h1000_0020); end
        checks++; if (pc_plus4 !== 32'h84) begin failures++; $display("FAIL hr_pc_plus4 actual=%h required=%h", pc_plus4, 32'h84); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL hr_valid_after actual=%b required=1", valid); end
    endtask

`ifdef FETCH_STEP_EN
    task automatic test_step();
        int n_valid;
        n_valid = 0;
        step_mode_i = 1'b1;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            step_i = (c == 3 || c == 8 || c == 13);
            @(negedge clk);
            step_i = 1'b0;
            if (valid === 1'b1) begin
                n_valid++;
                checks++; if (instr !== 32'h1000_0000 + n_valid - 1) begin failures++; $display("FAIL step_instr[%0d] actual=%h required=%h", n_valid, instr, 32'h1000_0000 + n_valid - 1); end
            end
        end
        checks++; if (n_valid != 3) begin failures++; $display("FAIL step_count actual=%0d required=3", n_valid); end
        checks++; if (pc !== 32'hC) begin failures++; $display("FAIL step_pc actual=%h required=%h", pc, 32'hC); end
        step_mode_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_redirect();
`ifdef FETCH_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
